// File: rtl/nw_uart_pkg.sv
// Shared definitions for the UART-to-NW-core loader path: state encoding,
// framing bytes and default memory geometry.
package nw_uart_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  localparam logic [7:0] TERM_BYTE = 8'h0A;
  localparam logic [7:0] SKIP_BYTE = 8'h0D;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_DONE   = 2'd2
  } load_state_t;

endpackage

// File: rtl/seq_load_addr_len_counter.sv
// Saturating symbol counter shared by sequences A and B; it never wraps,
// so an overlong sequence still reports exactly MAX symbols.
module seq_len_counter #(
  parameter int LEN_W = 4,
  parameter int MAX   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [LEN_W-1:0] o_count,
  output logic             o_at_max
);

  logic [LEN_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = (r_count == LEN_W'(MAX));

endmodule

// File: rtl/seq_load_addr.sv
// Writes a byte stream into sequence memories A then B at incrementing
// addresses, latching each length at its terminator byte.
//
// state    | meaning
// S_LOAD_A | filling memory A, waiting for first non-empty terminator
// S_LOAD_B | filling memory B, waiting for its terminator
// S_DONE   | both sequences loaded; input back-pressured until rst/clear
module seq_load_addr
  import nw_uart_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter int                DEPTH  = DEF_DEPTH,
  parameter int                ADDR_W = $clog2(DEPTH),
  parameter int                LEN_W  = $clog2(DEPTH + 1),
  parameter logic [DATA_W-1:0] TERM   = TERM_BYTE,
  parameter logic [DATA_W-1:0] SKIP   = SKIP_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we_a,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] wdata,
  output logic [LEN_W-1:0]  len_a,
  output logic [LEN_W-1:0]  len_b,
  output logic              done,
  output logic              err_ovf
);

  load_state_t       r_state;
  logic              r_we_a;
  logic              r_we_b;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [LEN_W-1:0]  r_len_a;
  logic [LEN_W-1:0]  r_len_b;
  logic              r_done;
  logic              r_err_ovf;

  logic              w_accept;
  logic              w_is_term;
  logic              w_is_skip;
  logic              w_is_sym;
  logic              w_term_adv;
  logic              w_write;
  logic              w_ovf;
  logic              w_cnt_clr;
  logic [LEN_W-1:0]  w_count;
  logic              w_at_max;

  assign in_ready   = (r_state != S_DONE) && !clear;
  assign w_accept   = in_valid && in_ready;
  assign w_is_term  = (in_data == TERM);
  assign w_is_skip  = (in_data == SKIP);
  assign w_is_sym   = !w_is_term && !w_is_skip;
  assign w_term_adv = w_accept && w_is_term && (w_count != '0);
  assign w_write    = w_accept && w_is_sym && !w_at_max;
  assign w_ovf      = w_accept && w_is_sym && w_at_max;
  assign w_cnt_clr  = clear || w_term_adv;

  seq_len_counter #(
    .LEN_W (LEN_W),
    .MAX   (DEPTH)
  ) u_len_counter (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_inc    (w_write),
    .i_clr    (w_cnt_clr),
    .o_count  (w_count),
    .o_at_max (w_at_max)
  );

  // clear shares the reset branch; a strobe registered last cycle is
  // already on the outputs and simply drops here.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state   <= S_LOAD_A;
      r_we_a    <= 1'b0;
      r_we_b    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_len_a   <= '0;
      r_len_b   <= '0;
      r_done    <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_we_a <= 1'b0;
      r_we_b <= 1'b0;

      if (w_write) begin
        r_we_a  <= (r_state == S_LOAD_A);
        r_we_b  <= (r_state == S_LOAD_B);
        r_addr  <= w_count[ADDR_W-1:0];
        r_wdata <= in_data;
      end

      if (w_ovf) begin
        r_err_ovf <= 1'b1;
      end

      if (w_term_adv) begin
        case (r_state)
          S_LOAD_A: begin
            r_len_a <= w_count;
            r_state <= S_LOAD_B;
          end
          S_LOAD_B: begin
            r_len_b <= w_count;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
          default: r_state <= S_DONE;
        endcase
      end
    end
  end

  assign we_a    = r_we_a;
  assign we_b    = r_we_b;
  assign addr_w  = r_addr;
  assign wdata   = r_wdata;
  assign len_a   = r_len_a;
  assign len_b   = r_len_b;
  assign done    = r_done;
  assign err_ovf = r_err_ovf;

endmodule

// File: tb/tb_seq_load_addr.sv
// Per-cycle directed vectors for seq_load_addr with hand-computed strobes,
// lengths and flags, plus a short sequence for a strobe overlapping clear.
module tb_seq_load_addr;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       we_a;
  logic       we_b;
  logic [2:0] addr_w;
  logic [7:0] wdata;
  logic [3:0] len_a;
  logic [3:0] len_b;
  logic       done;
  logic       err_ovf;

  seq_load_addr dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we_a     (we_a),
    .we_b     (we_b),
    .addr_w   (addr_w),
    .wdata    (wdata),
    .len_a    (len_a),
    .len_b    (len_b),
    .done     (done),
    .err_ovf  (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       vld;
    logic [7:0] data;
    logic       ck_rdy;
    logic       rdy;
    logic       wa;
    logic       wb;
    logic       ck_aw;
    logic [2:0] addr;
    logic [7:0] wd;
    logic [3:0] la;
    logic [3:0] lb;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int cur_idx = 0;

  logic [3:0] cur_la, cur_lb;
  logic       cur_dn, cur_er;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %0h, want %0h", nm, cur_idx, act, exp);
    end
  endtask

  task automatic put(input logic r, input logic c, input logic v, input logic [7:0] d,
                     input logic ckr, input logic rdy, input logic wa, input logic wb,
                     input logic cka, input logic [2:0] a, input logic [7:0] wd);
    vec_t x;
    x.rst = r; x.clr = c; x.vld = v; x.data = d;
    x.ck_rdy = ckr; x.rdy = rdy; x.wa = wa; x.wb = wb;
    x.ck_aw = cka; x.addr = a; x.wd = wd;
    x.la = cur_la; x.lb = cur_lb; x.dn = cur_dn; x.er = cur_er;
    tbl.push_back(x);
  endtask

  task automatic zero_exp();
    cur_la = 0; cur_lb = 0; cur_dn = 0; cur_er = 0;
  endtask

  task automatic wa_(input logic [7:0] d, input logic [2:0] a);
    put(0, 0, 1, d, 1, 1, 1, 0, 1, a, d);
  endtask

  task automatic wb_(input logic [7:0] d, input logic [2:0] a);
    put(0, 0, 1, d, 1, 1, 0, 1, 1, a, d);
  endtask

  task automatic nop(input logic [7:0] d, input logic rdy);
    put(0, 0, 1, d, 1, rdy, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    put(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0);
  endtask

  // clear (or rst) vector: everything back at reset values after the edge
  task automatic restart(input logic r, input logic c, input logic v, input logic [7:0] d,
                         input logic ckr, input logic rdy);
    zero_exp();
    put(r, c, v, d, ckr, rdy, 0, 0, 1, 0, 0);
  endtask

  task automatic build();
    logic [7:0] syms [8];
    syms = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h41, 8'h43, 8'h47, 8'h54};
    zero_exp();
    restart(1, 0, 0, 8'h00, 0, 0);
    // "ACG\n" "TTA\n" at full rate
    wa_(8'h41, 0); wa_(8'h43, 1); wa_(8'h47, 2);
    cur_la = 3; nop(8'h0A, 1);
    wb_(8'h54, 0); wb_(8'h54, 1); wb_(8'h41, 2);
    cur_lb = 3; cur_dn = 1; nop(8'h0A, 1);
    // done holds off input
    nop(8'h47, 0); nop(8'h47, 0);
    restart(0, 1, 1, 8'h47, 1, 0);
    wa_(8'h47, 0);
    restart(1, 0, 0, 8'h00, 1, 1);
    // "\n\r\nGA\r\nC\n"
    nop(8'h0A, 1); nop(8'h0D, 1); nop(8'h0A, 1);
    wa_(8'h47, 0); wa_(8'h41, 1); nop(8'h0D, 1);
    cur_la = 2; nop(8'h0A, 1);
    wb_(8'h43, 0);
    cur_lb = 1; cur_dn = 1; nop(8'h0A, 1);
    // overflow: 10 symbols then "\n", then "A\n"
    restart(0, 1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) wa_(syms[i], 3'(i));
    cur_er = 1; nop(8'h41, 1); nop(8'h43, 1);
    cur_la = 8; nop(8'h0A, 1);
    wb_(8'h41, 0);
    cur_lb = 1; cur_dn = 1; nop(8'h0A, 1);
    // gapped input during B
    restart(0, 1, 0, 8'h00, 1, 0);
    wa_(8'h41, 0); wa_(8'h43, 1);
    cur_la = 2; nop(8'h0A, 1);
    wb_(8'h54, 0); idle(); idle();
    wb_(8'h47, 1); idle(); idle();
    wb_(8'h41, 2); idle(); idle();
    cur_lb = 3; cur_dn = 1; nop(8'h0A, 1);
    // rst together with clear in the middle of B
    restart(0, 1, 0, 8'h00, 1, 0);
    wa_(8'h47, 0); wa_(8'h41, 1);
    cur_la = 2; nop(8'h0A, 1);
    wb_(8'h54, 0);
    restart(1, 1, 1, 8'h43, 1, 0);
    wa_(8'h41, 0); wa_(8'h43, 1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    build();

    foreach (tbl[i]) begin
      cur_idx = i;
      @(negedge clk);
      rst = tbl[i].rst; clear = tbl[i].clr;
      in_valid = tbl[i].vld; in_data = tbl[i].data;
      #1;
      if (tbl[i].ck_rdy) chk("in_ready", 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      n_vec++;
      chk("we_a", 32'(we_a), 32'(tbl[i].wa));
      chk("we_b", 32'(we_b), 32'(tbl[i].wb));
      if (tbl[i].ck_aw) begin
        chk("addr_w", 32'(addr_w), 32'(tbl[i].addr));
        chk("wdata", 32'(wdata), 32'(tbl[i].wd));
      end
      chk("len_a", 32'(len_a), 32'(tbl[i].la));
      chk("len_b", 32'(len_b), 32'(tbl[i].lb));
      chk("done", 32'(done), 32'(tbl[i].dn));
      chk("err_ovf", 32'(err_ovf), 32'(tbl[i].er));
    end

    // Strobe accepted the cycle before clear is still visible during clear.
    cur_idx = -1;
    @(negedge clk);
    rst = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 8'h54;
    #1;
    chk("hs in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    n_vec++;
    chk("hs we_a", 32'(we_a), 32'd1);
    chk("hs addr_w", 32'(addr_w), 32'd2);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    #1;
    chk("hs we_a in clear", 32'(we_a), 32'd1);
    chk("hs in_ready in clear", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    n_vec++;
    chk("hs we_a after clear", 32'(we_a), 32'd0);
    chk("hs addr_w after clear", 32'(addr_w), 32'd0);
    chk("hs wdata after clear", 32'(wdata), 32'd0);
    chk("hs len_a after clear", 32'(len_a), 32'd0);
    @(negedge clk);
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
